prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Program-memory front end that sits directly upstream of the fetch stage.
- Receives a byte stream over a valid/ready handshake and assembles it into 15-bit instructions.
- Writes the instructions into a 256-entry instruction memory, which fetch reads through a combinational read port.
- Holds the CPU in reset (cpu_hold) until a load completes with a correct checksum.

Parameters:
- ADDR_W, 8, instruction memory address width; depth is 2**ADDR_W (256), matching the 8-bit p_count.
- INSN_W, 15, instruction width; fixed by the instruction format; not to be changed.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- load_req  input  1  single-cycle request to start (or restart) a load.
- in_valid  input  1  byte source has in_data valid.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts a byte this cycle.
- rd_addr  input  ADDR_W  fetch read address (driven by p_count).
- rd_data  output  INSN_W  combinational read: mem[rd_addr].
- cpu_hold  output  1  high = CPU held in reset; top level ORs it into the CPU reset.
- load_done  output  1  last load succeeded.
- load_err  output  1  last load failed (format or checksum).
- words_loaded  output  9  words written in the current or last load, 0..256.

Behaviour:
- Reset values (asynchronous):
  - state=IDLE, in_ready=0, cpu_hold=1, load_done=0, load_err=0, words_loaded=0.
  - Internal write addr=0, remaining=0, checksum=0.
  - Memory contents are not reset.
- A byte is accepted on a rising edge where in_valid && in_ready. Bytes presented while in_ready=0 are ignored and never buffered.
- in_ready is registered: 1 exactly in states COUNT, HI, LO, CHK; 0 otherwise.
- Stream format:
  - COUNT byte N (0 encodes 256).
  - N pairs of bytes: HI then LO. HI[7] must be 0; the instruction is {HI[6:0], LO}.
  - One CHK byte.
- Checksum: running XOR of the COUNT byte and every HI/LO byte; the CHK byte is excluded.
- State machine:
  - IDLE/DONE/ERROR: in_ready=0; wait for load_req.
  - load_req from any state (including mid-load) takes effect on the next edge:
    - go to COUNT;
    - clear addr, checksum, words_loaded;
    - set cpu_hold=1, load_done=0, load_err=0.
    - load_req takes priority over a byte accepted on the same edge; that byte is discarded.
  - COUNT: on accept, remaining = (byte==0) ? 256 : byte; go to HI.
  - HI: on accept, if byte[7]=1 go to ERROR with load_err=1 and no memory write; else latch byte[6:0] and go to LO.
  - LO: on accept:
    - write mem[addr] = {hi, byte} on that edge;
    - addr++ (wraps 255->0 internally);
    - words_loaded++;
    - remaining--;
    - if remaining reaches 0 go to CHK, else go to HI.
  - CHK: on accept:
    - byte == checksum: go to DONE, load_done=1, cpu_hold=0.
    - Mismatch: go to ERROR, load_err=1, cpu_hold stays 1.
- cpu_hold drops only on the CHK accept edge of a good load. It rises on load_req or reset.
- Read port:
  - rd_data is combinational. A write to the addressed location is visible on the cycle after the write edge; there is no write-through bypass.
  - A read during a load returns whatever is currently stored (partially overwritten contents).
- Reset mid-load: immediate return to IDLE with cpu_hold=1. Already-written words are kept.
- Implementation: target 120–400 lines RTL; memory as a register array.

Test Plan:
- Reset values:
  - stimulus: assert reset, sample outputs;
  - response: in_ready=0, cpu_hold=1, load_done=0, load_err=0, words_loaded=0.
- Good load:
  - stimulus: load_req, then bytes 02, 12, 34, 05, 6A, CHK=02^12^34^05^6A=4B;
  - response: load_done=1, cpu_hold=0, words_loaded=2, rd_addr=0 gives 15'h1234, rd_addr=1 gives 15'h056A.
- Bad checksum:
  - stimulus: same stream with CHK=4C;
  - response: load_err=1, cpu_hold=1, load_done=0, in_ready=0; words_loaded=2 and data still written.
- Format error:
  - stimulus: COUNT=01, HI=80;
  - response: ERROR immediately, load_err=1, no write to mem[0].
- Handshake stalls:
  - stimulus: random in_valid gaps; bytes driven while in state IDLE; load_req asserted on the same edge as a HI accept;
  - response: only handshaked bytes are counted; the restart discards the byte; the next accepted byte is taken as COUNT.
- Full depth:
  - stimulus: COUNT=00, then 256 words whose value equals the index;
  - response: words_loaded=256, mem[255]=15'h00FF, mem[0]=0, done.
- Mid-load reset:
  - stimulus: reset after 3 words;
  - response: IDLE, cpu_hold=1, and those 3 words remain readable.

Source files
------------

// File: rtl/prog_loader.sv
// prog_loader: program-memory front end sitting directly upstream of fetch.
// It assembles a byte stream into 15-bit instructions, writes them into a
// 256-entry instruction memory and keeps the CPU in reset until a load
// finishes with a matching checksum.
//
// Stream: COUNT (0 means 256), COUNT pairs of HI/LO bytes, then CHK.
// HI[7] must be 0; each instruction is {HI[6:0], LO}. CHK must equal the XOR
// of COUNT and every HI/LO byte.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   load_req            one-cycle request to start or restart a load
//   in_valid, in_data   byte source; in_ready says a byte is taken this cycle
//   rd_addr, rd_data    combinational fetch read port, rd_data = mem[rd_addr]
//   cpu_hold            1 = CPU held in reset
//   load_done/load_err  result of the last load
//   words_loaded        words written in the current or last load (0..256)
module prog_loader #(
  parameter int ADDR_W = 8,
  parameter int INSN_W = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_req,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [INSN_W-1:0] rd_data,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [8:0]        words_loaded
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {IDLE, COUNT, HI, LO, CHK, DONE, ERROR} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] addr, addr_next;
  logic [8:0]        remaining, remaining_next;
  logic [7:0]        checksum, checksum_next;
  logic [6:0]        hi, hi_next;
  logic [8:0]        words_loaded_next;
  logic              in_ready_next;
  logic              cpu_hold_next;
  logic              load_done_next;
  logic              load_err_next;
  logic              accept;
  logic              we;

  logic [INSN_W-1:0] mem [DEPTH];

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      addr         <= '0;
      remaining    <= '0;
      checksum     <= '0;
      hi           <= '0;
      words_loaded <= '0;
      in_ready     <= 1'b0;
      cpu_hold     <= 1'b1;
      load_done    <= 1'b0;
      load_err     <= 1'b0;
    end else begin
      state        <= state_next;
      addr         <= addr_next;
      remaining    <= remaining_next;
      checksum     <= checksum_next;
      hi           <= hi_next;
      words_loaded <= words_loaded_next;
      in_ready     <= in_ready_next;
      cpu_hold     <= cpu_hold_next;
      load_done    <= load_done_next;
      load_err     <= load_err_next;
    end
  end

  always_comb begin
    state_next        = state;
    addr_next         = addr;
    remaining_next    = remaining;
    checksum_next     = checksum;
    hi_next           = hi;
    words_loaded_next = words_loaded;
    cpu_hold_next     = cpu_hold;
    load_done_next    = load_done;
    load_err_next     = load_err;
    we                = 1'b0;

    // A restart wins over any byte handshaked on the same edge; that byte
    // is dropped rather than interpreted as COUNT.
    if (load_req) begin
      state_next        = COUNT;
      addr_next         = '0;
      checksum_next     = '0;
      words_loaded_next = '0;
      cpu_hold_next     = 1'b1;
      load_done_next    = 1'b0;
      load_err_next     = 1'b0;
    end else if (accept) begin
      case (state)
        COUNT: begin
          remaining_next = (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
          checksum_next  = checksum ^ in_data;
          state_next     = HI;
        end
        HI: begin
          if (in_data[7]) begin
            state_next    = ERROR;
            load_err_next = 1'b1;
          end else begin
            hi_next       = in_data[6:0];
            checksum_next = checksum ^ in_data;
            state_next    = LO;
          end
        end
        LO: begin
          we                = 1'b1;
          addr_next         = addr + 1'b1;
          words_loaded_next = words_loaded + 9'd1;
          remaining_next    = remaining - 9'd1;
          checksum_next     = checksum ^ in_data;
          state_next        = (remaining == 9'd1) ? CHK : HI;
        end
        CHK: begin
          if (in_data == checksum) begin
            state_next     = DONE;
            load_done_next = 1'b1;
            cpu_hold_next  = 1'b0;
          end else begin
            state_next    = ERROR;
            load_err_next = 1'b1;
          end
        end
        default: state_next = state;
      endcase
    end

    // in_ready is registered from the next state so it is glitch-free.
    in_ready_next = (state_next == COUNT) || (state_next == HI) ||
                    (state_next == LO)    || (state_next == CHK);
  end

  // Memory is deliberately not reset: words survive a mid-load reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= {hi, in_data};
    end
  end

  // No write-through: a new word appears on the cycle after its write edge.
  assign rd_data = mem[rd_addr];

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

  logic        clk;
  logic        reset;
  logic        load_req;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [7:0]  rd_addr;
  logic [14:0] rd_data;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;
  logic [8:0]  words_loaded;

  int checks = 0;
  int failures = 0;

  // Reference memory image: what the stream rules say has been written.
  logic [14:0] model_mem [256];
  bit          model_known [256];

  typedef struct {
    int          n;          // number of stream bytes used
    logic [63:0] bytes;      // stream, first byte in bits 63:56
    logic        exp_done;
    logic        exp_err;
    logic [8:0]  exp_words;
    logic [14:0] exp_m0;
    logic [14:0] exp_m1;
    logic        chk_m1;
  } vec_t;

  vec_t vecs[5];

  prog_loader dut (
    .clk          (clk),
    .reset        (reset),
    .load_req     (load_req),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .cpu_hold     (cpu_hold),
    .load_done    (load_done),
    .load_err     (load_err),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Offer one byte with random gaps until it is handshaked; returns just
  // after the accepting rising edge.
  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
      end else begin
        in_valid = 1'b1;
        in_data  = b;
        ok       = in_ready;
      end
    end
    if (ok) begin
      @(posedge clk);
    end else begin
      in_valid = 1'b0;
      checks++;
      failures++;
      $display("FAIL send_byte_timeout actual=no_accept expected=accept byte=%0h", b);
    end
  endtask

  task automatic send_stream(input logic [7:0] q[$]);
    foreach (q[i]) send_byte(q[i]);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pulse_load_req();
    @(negedge clk);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    check("after_req_ready", in_ready, 1);
    check("after_req_hold", cpu_hold, 1);
    check("after_req_words", words_loaded, 0);
  endtask

  // Interpret a (possibly truncated) stream by its rules and update the
  // reference memory. done/err describe a completed load only.
  task automatic model_apply(input logic [7:0] q[$], output logic done,
                             output logic err, output logic [8:0] words);
    int n, idx, addr;
    logic [7:0] csum, hb, lb;
    done = 0; err = 0; words = 0;
    if (q.size() == 0) return;
    n    = (q[0] == 0) ? 256 : int'(q[0]);
    csum = q[0];
    idx  = 1;
    addr = 0;
    for (int w = 0; w < n; w++) begin
      if (idx >= q.size()) return;
      hb = q[idx];
      if (hb[7]) begin
        err = 1;
        return;
      end
      csum ^= hb;
      idx++;
      if (idx >= q.size()) return;
      lb = q[idx];
      csum ^= lb;
      idx++;
      model_mem[addr]   = {hb[6:0], lb};
      model_known[addr] = 1;
      addr  = (addr + 1) % 256;
      words = words + 9'd1;
    end
    if (idx >= q.size()) return;
    if (q[idx] == csum) done = 1;
    else err = 1;
  endtask

  task automatic check_mem(input string tag);
    for (int a = 0; a < 256; a++) begin
      if (model_known[a]) begin
        rd_addr = 8'(a);
        #1;
        check($sformatf("%s_mem[%0d]", tag, a), rd_data, model_mem[a]);
      end
    end
  endtask

  task automatic read_check(input string name, input int a, input logic [14:0] exp);
    rd_addr = 8'(a);
    #1;
    check(name, rd_data, exp);
  endtask

  initial begin
    logic [7:0]  q[$];
    logic        m_done, m_err;
    logic [8:0]  m_words;
    logic [7:0]  cs;

    foreach (model_known[i]) model_known[i] = 0;
    reset = 1'b1; load_req = 1'b0; in_valid = 1'b0; in_data = 8'h00; rd_addr = 8'h00;

    // Reset values, with bytes offered while in reset and then in IDLE.
    repeat (2) @(negedge clk);
    check("rst_ready", in_ready, 0);
    check("rst_hold", cpu_hold, 1);
    check("rst_done", load_done, 0);
    check("rst_err", load_err, 0);
    check("rst_words", words_loaded, 0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("idle_ready", in_ready, 0);
    check("idle_words", words_loaded, 0);
    check("idle_hold", cpu_hold, 1);

    // Table vectors; order matters (vector 2 relies on mem[0] from vector 1).
    vecs[0] = '{6, 64'h021234056A4B0000, 1'b1, 1'b0, 9'd2, 15'h1234, 15'h056A, 1'b1};
    vecs[1] = '{6, 64'h021234056A4C0000, 1'b0, 1'b1, 9'd2, 15'h1234, 15'h056A, 1'b1};
    vecs[2] = '{2, 64'h0180000000000000, 1'b0, 1'b1, 9'd0, 15'h1234, 15'h0000, 1'b0};
    vecs[3] = '{4, 64'h017FFF8100000000, 1'b1, 1'b0, 9'd1, 15'h7FFF, 15'h0000, 1'b0};
    vecs[4] = '{4, 64'h0100000000000000, 1'b0, 1'b1, 9'd1, 15'h0000, 15'h0000, 1'b0};
    for (int v = 0; v < 5; v++) begin
      q = {};
      for (int j = 0; j < vecs[v].n; j++) q.push_back(vecs[v].bytes[63-8*j -: 8]);
      pulse_load_req();
      send_stream(q);
      model_apply(q, m_done, m_err, m_words);
      check($sformatf("vec%0d_done", v), load_done, vecs[v].exp_done);
      check($sformatf("vec%0d_err", v), load_err, vecs[v].exp_err);
      check($sformatf("vec%0d_hold", v), cpu_hold, !vecs[v].exp_done);
      check($sformatf("vec%0d_ready", v), in_ready, 0);
      check($sformatf("vec%0d_words", v), words_loaded, vecs[v].exp_words);
      read_check($sformatf("vec%0d_m0", v), 0, vecs[v].exp_m0);
      if (vecs[v].chk_m1) read_check($sformatf("vec%0d_m1", v), 1, vecs[v].exp_m1);
    end

    // Restart on the same edge as a HI accept: that byte must be dropped.
    pulse_load_req();
    q = {8'h03};
    send_stream(q);
    @(negedge clk);
    check("restart_in_hi_ready", in_ready, 1);
    load_req = 1'b1; in_valid = 1'b1; in_data = 8'h05;
    @(negedge clk);
    load_req = 1'b0; in_valid = 1'b0;
    check("restart_words", words_loaded, 0);
    check("restart_ready", in_ready, 1);
    q = {8'h01, 8'h55, 8'hAA, 8'hFE};
    send_stream(q);
    model_apply(q, m_done, m_err, m_words);
    check("restart_done", load_done, 1);
    check("restart_words_final", words_loaded, 1);
    read_check("restart_m0", 0, 15'h55AA);

    // Full depth: COUNT=0 means 256 words, word i = i.
    pulse_load_req();
    q = {8'h00};
    cs = 8'h00;
    for (int i = 0; i < 256; i++) begin
      q.push_back(8'h00);
      q.push_back(8'(i));
      cs ^= 8'(i);
    end
    q.push_back(cs);
    send_stream(q);
    model_apply(q, m_done, m_err, m_words);
    check("full_done", load_done, 1);
    check("full_hold", cpu_hold, 0);
    check("full_words", words_loaded, 256);
    read_check("full_m255", 255, 15'h00FF);
    read_check("full_m0", 0, 15'h0000);
    check_mem("full");

    // Mid-load reset after 3 words.
    pulse_load_req();
    q = {8'h05};
    for (int i = 0; i < 3; i++) begin
      q.push_back(8'($urandom_range(0, 127)));
      q.push_back(8'($urandom));
    end
    foreach (q[i]) send_byte(q[i]);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_hold_async", cpu_hold, 1);
    check("midrst_ready_async", in_ready, 0);
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b0;
    model_apply(q, m_done, m_err, m_words);
    check("midrst_words", words_loaded, 0);
    check("midrst_done", load_done, 0);
    check("midrst_err", load_err, 0);
    check_mem("midrst");

    // Randomized loads against the stream-level model.
    for (int t = 0; t < 20; t++) begin
      int n, mode, k;
      logic [7:0] hb, chk;
      if ($urandom_range(0, 2) == 0) begin
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          in_valid = 1'b1;
          in_data  = 8'($urandom);
        end
        @(negedge clk);
        in_valid = 1'b0;
        check($sformatf("rnd%0d_idle_ready", t), in_ready, 0);
      end
      n    = $urandom_range(1, 24);
      mode = $urandom_range(0, 2);
      k    = $urandom_range(0, n - 1);
      q    = {8'(n)};
      chk  = 8'(n);
      for (int w = 0; w < n; w++) begin
        hb = 8'($urandom_range(0, 127));
        if (mode == 2 && w == k) begin
          q.push_back(hb | 8'h80);
          break;
        end
        q.push_back(hb);
        chk ^= hb;
        q.push_back(8'($urandom));
        chk ^= q[q.size()-1];
      end
      if (mode != 2) begin
        if (mode == 1) chk ^= 8'(1 << $urandom_range(0, 7));
        q.push_back(chk);
      end
      pulse_load_req();
      send_stream(q);
      model_apply(q, m_done, m_err, m_words);
      check($sformatf("rnd%0d_done", t), load_done, m_done);
      check($sformatf("rnd%0d_err", t), load_err, m_err);
      check($sformatf("rnd%0d_hold", t), cpu_hold, !m_done);
      check($sformatf("rnd%0d_words", t), words_loaded, m_words);
      check($sformatf("rnd%0d_ready", t), in_ready, 0);
      check_mem($sformatf("rnd%0d", t));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
